peripheral_msi_slave_port_ahb3: RTL and testbench

Slave-side port of the MSI AHB3-Lite interconnect, one instance per AHB slave. It collects connection requests from all MASTERS master ports, arbitrates by 3-bit priority, returns per-master grants and muxes the winner's address and data phase onto the single AHB slave. Slave responses (HREADYOUT, HRESP, HRDATA) are routed back to the master ports.

---
 rtl/peripheral_ahb3_pkg.sv | 27 ++
 rtl/peripheral_msi_arbiter_ahb3.sv | 83 ++++++++
 rtl/peripheral_msi_slave_port_ahb3.sv | 160 ++++++++++++++++
 tb/tb_peripheral_msi_slave_port_ahb3.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_pkg
//   Shared AHB3-Lite encodings (HTRANS, HBURST, HRESP) plus the state type used
//   by the MSI slave-port arbitration FSM.
// -----------------------------------------------------------------------------
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {ARB_IDLE, ARB_ACTIVE} arb_state_t;

endpackage

// File: rtl/peripheral_msi_arbiter_ahb3.sv
// -----------------------------------------------------------------------------
// peripheral_msi_arbiter_ahb3
//   Picks one requesting master: highest 3-bit priority wins, ties broken by
//   lowest index, or round-robin from last_granted+1 when
//   MSI_SLAVE_PORT_RR_EN is defined.
// Ports:
//   HCLK, HRESETn, grant_load  (only with MSI_SLAVE_PORT_RR_EN) pointer update
//   req      [MASTERS]        request per master
//   prio     [MASTERS][3]     priority per master, 7 highest
//   win_oh   [MASTERS]        one-hot winner (all zero if no request)
//   any_req                   at least one request
// -----------------------------------------------------------------------------
module peripheral_msi_arbiter_ahb3
  import peripheral_ahb3_pkg::*;
#(
  parameter int MASTERS = 5
) (
`ifdef MSI_SLAVE_PORT_RR_EN
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    grant_load,
`endif
  input  logic [MASTERS-1:0]      req,
  input  logic [MASTERS-1:0][2:0] prio,
  output logic [MASTERS-1:0]      win_oh,
  output logic                    any_req
);

  localparam int MASTER_BITS = $clog2(MASTERS);

  logic [2:0]             top_prio;
  logic [MASTER_BITS-1:0] start_idx;
  logic [MASTER_BITS-1:0] idx;
  logic [MASTER_BITS:0]   sum;
  logic                   found;

`ifdef MSI_SLAVE_PORT_RR_EN
  logic [MASTER_BITS-1:0] last_granted;
  logic [MASTER_BITS-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < MASTERS; i++)
      if (win_oh[i]) win_idx = MASTER_BITS'(i);
  end

  // Pointer starts at the last master so master 0 is first in line.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)        last_granted <= MASTER_BITS'(MASTERS-1);
    else if (grant_load) last_granted <= win_idx;
  end

  assign start_idx = (last_granted == MASTER_BITS'(MASTERS-1)) ? '0
                                                               : last_granted + 1'b1;
`else
  assign start_idx = '0;
`endif

  assign any_req = |req;

  // Two passes: find the top priority, then the first requester at that
  // priority scanning upward (with wrap) from start_idx.
  always_comb begin
    top_prio = '0;
    for (int i = 0; i < MASTERS; i++)
      if (req[i] && prio[i] > top_prio) top_prio = prio[i];

    win_oh = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < MASTERS; k++) begin
      sum = {1'b0, start_idx} + (MASTER_BITS+1)'(k);
      if (sum >= (MASTER_BITS+1)'(MASTERS)) sum = sum - (MASTER_BITS+1)'(MASTERS);
      idx = sum[MASTER_BITS-1:0];
      if (!found && req[idx] && prio[idx] == top_prio) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_msi_slave_port_ahb3.sv
// -----------------------------------------------------------------------------
// peripheral_msi_slave_port_ahb3
//   Slave side of the MSI AHB3-Lite interconnect. Arbitrates the master ports
//   that request this slave, muxes the owner's address phase and the data-phase
//   owner's write data to the slave, and routes HREADYOUT/HRESP back to the
//   data-phase owner. HRDATA is broadcast.
//   Optional: MSI_SLAVE_PORT_RR_EN selects round-robin tie-breaking.
// Ports:
//   HCLK, HRESETn (sync, active low)
//   mstpriority/mstHSEL/mstH*        per-master request and address phase
//   mstHWDATA, mstHREADY             per-master data phase inputs
//   mst_HRDATA, mst_HREADYOUT, mst_HRESP   responses to the master ports
//   can_switch                       owner allows re-arbitration
//   master_granted                   one-hot address-phase grant
//   slv_*                            AHB slave side
// -----------------------------------------------------------------------------
module peripheral_msi_slave_port_ahb3
  import peripheral_ahb3_pkg::*;
#(
  parameter int PLEN    = 64,
  parameter int XLEN    = 64,
  parameter int MASTERS = 5
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,

  input  logic [MASTERS-1:0][2:0]      mstpriority,
  input  logic [MASTERS-1:0]           mstHSEL,
  input  logic [MASTERS-1:0][PLEN-1:0] mstHADDR,
  input  logic [MASTERS-1:0][XLEN-1:0] mstHWDATA,
  input  logic [MASTERS-1:0]           mstHWRITE,
  input  logic [MASTERS-1:0][2:0]      mstHSIZE,
  input  logic [MASTERS-1:0][2:0]      mstHBURST,
  input  logic [MASTERS-1:0][3:0]      mstHPROT,
  input  logic [MASTERS-1:0][1:0]      mstHTRANS,
  input  logic [MASTERS-1:0]           mstHMASTLOCK,
  input  logic [MASTERS-1:0]           mstHREADY,
  output logic [XLEN-1:0]              mst_HRDATA,
  output logic [MASTERS-1:0]           mst_HREADYOUT,
  output logic [MASTERS-1:0]           mst_HRESP,

  input  logic [MASTERS-1:0]      can_switch,
  output logic [MASTERS-1:0]      master_granted,

  output logic                    slv_HSEL,
  output logic [PLEN-1:0]         slv_HADDR,
  output logic [XLEN-1:0]         slv_HWDATA,
  output logic                    slv_HWRITE,
  output logic [2:0]              slv_HSIZE,
  output logic [2:0]              slv_HBURST,
  output logic [3:0]              slv_HPROT,
  output logic [1:0]              slv_HTRANS,
  output logic                    slv_HMASTLOCK,
  output logic                    slv_HREADY,
  input  logic                    slv_HREADYOUT,
  input  logic                    slv_HRESP,
  input  logic [XLEN-1:0]         slv_HRDATA
);

  localparam int MASTER_BITS = $clog2(MASTERS);

  arb_state_t             state, nxt_state;
  logic [MASTER_BITS-1:0] addr_owner, nxt_owner, data_owner, win_idx;
  logic                   data_valid, any_req, grant_load, granted;
  logic [MASTERS-1:0]     win_oh;

  peripheral_msi_arbiter_ahb3 #(.MASTERS(MASTERS)) u_arb (
`ifdef MSI_SLAVE_PORT_RR_EN
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .grant_load (grant_load),
`endif
    .req        (mstHSEL),
    .prio       (mstpriority),
    .win_oh     (win_oh),
    .any_req    (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < MASTERS; i++)
      if (win_oh[i]) win_idx = MASTER_BITS'(i);
  end

  // Re-arbitration only at a completed transfer boundary the owner agrees to;
  // a locked owner keeps the slave no matter who else asks.
  always_comb begin
    nxt_state  = state;
    nxt_owner  = addr_owner;
    grant_load = 1'b0;
    case (state)
      ARB_IDLE:
        if (any_req) begin
          nxt_state  = ARB_ACTIVE;
          nxt_owner  = win_idx;
          grant_load = 1'b1;
        end
      ARB_ACTIVE:
        if (slv_HREADYOUT && can_switch[addr_owner] && !mstHMASTLOCK[addr_owner]) begin
          if (any_req) begin
            nxt_owner  = win_idx;
            grant_load = 1'b1;
          end else begin
            nxt_state  = ARB_IDLE;
          end
        end
      default: nxt_state = ARB_IDLE;
    endcase
  end

  // The data phase follows the address phase on every accepted beat, so a
  // new owner's address phase overlaps the previous owner's data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ARB_IDLE;
      addr_owner <= '0;
      data_owner <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= nxt_state;
      addr_owner <= nxt_owner;
      if (slv_HREADYOUT) begin
        data_owner <= addr_owner;
        data_valid <= slv_HSEL && (slv_HTRANS != HTRANS_IDLE);
      end
    end
  end

  assign granted = (state == ARB_ACTIVE);

  always_comb begin
    master_granted = '0;
    if (granted) master_granted[addr_owner] = 1'b1;
  end

  // Address phase mux
  assign slv_HSEL      = granted && mstHSEL[addr_owner];
  assign slv_HTRANS    = granted ? mstHTRANS[addr_owner] : HTRANS_IDLE;
  assign slv_HADDR     = mstHADDR[addr_owner];
  assign slv_HWRITE    = mstHWRITE[addr_owner];
  assign slv_HSIZE     = mstHSIZE[addr_owner];
  assign slv_HBURST    = mstHBURST[addr_owner];
  assign slv_HPROT     = mstHPROT[addr_owner];
  assign slv_HMASTLOCK = mstHMASTLOCK[addr_owner];

  // Data phase mux
  assign slv_HWDATA = mstHWDATA[data_owner];
  assign slv_HREADY = data_valid ? mstHREADY[data_owner] : 1'b1;
  assign mst_HRDATA = slv_HRDATA;

  always_comb begin
    mst_HREADYOUT = '1;
    mst_HRESP     = {MASTERS{HRESP_OKAY}};
    if (data_valid) begin
      mst_HREADYOUT[data_owner] = slv_HREADYOUT;
      mst_HRESP[data_owner]     = slv_HRESP;
    end
  end

endmodule

// File: tb/tb_peripheral_msi_slave_port_ahb3.sv
module tb_peripheral_msi_slave_port_ahb3;
  import peripheral_ahb3_pkg::*;

  localparam int M = 5, PLEN = 64, XLEN = 64;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic [M-1:0][2:0]      mstpriority;
  logic [M-1:0]           mstHSEL;
  logic [M-1:0][PLEN-1:0] mstHADDR;
  logic [M-1:0][XLEN-1:0] mstHWDATA;
  logic [M-1:0]           mstHWRITE;
  logic [M-1:0][2:0]      mstHSIZE;
  logic [M-1:0][2:0]      mstHBURST;
  logic [M-1:0][3:0]      mstHPROT;
  logic [M-1:0][1:0]      mstHTRANS;
  logic [M-1:0]           mstHMASTLOCK;
  logic [M-1:0]           mstHREADY;
  logic [XLEN-1:0]        mst_HRDATA;
  logic [M-1:0]           mst_HREADYOUT;
  logic [M-1:0]           mst_HRESP;
  logic [M-1:0]           can_switch;
  logic [M-1:0]           master_granted;
  logic                   slv_HSEL;
  logic [PLEN-1:0]        slv_HADDR;
  logic [XLEN-1:0]        slv_HWDATA;
  logic                   slv_HWRITE;
  logic [2:0]             slv_HSIZE;
  logic [2:0]             slv_HBURST;
  logic [3:0]             slv_HPROT;
  logic [1:0]             slv_HTRANS;
  logic                   slv_HMASTLOCK;
  logic                   slv_HREADY;
  logic                   slv_HREADYOUT;
  logic                   slv_HRESP;
  logic [XLEN-1:0]        slv_HRDATA;

  peripheral_msi_slave_port_ahb3 #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
    .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
    .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
    .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
    .mst_HRDATA(mst_HRDATA), .mst_HREADYOUT(mst_HREADYOUT), .mst_HRESP(mst_HRESP),
    .can_switch(can_switch), .master_granted(master_granted),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HREADY(slv_HREADY), .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP),
    .slv_HRDATA(slv_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the address phase (if anyone), who owns the
  // pending data phase, and the round-robin pointer.
  bit         m_act = 1'b0;
  logic [2:0] m_own = '0;
  logic [2:0] m_down = '0;
  bit         m_dv = 1'b0;
  int         m_last = M-1;

  typedef struct {
    logic [M-1:0]      req;
    logic [M-1:0][2:0] prio;
    logic [M-1:0]      want;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Winner = requester with the smallest key; key orders by priority first,
  // then by distance from the tie-break start position.
  function automatic int pick();
    int best = -1, bkey = 0, key, start;
`ifdef MSI_SLAVE_PORT_RR_EN
    start = (m_last + 1) % M;
`else
    start = 0;
`endif
    for (int i = 0; i < M; i++)
      if (mstHSEL[i]) begin
        key = (7 - int'(mstpriority[i])) * 100 + (i - start + M) % M;
        if (best < 0 || key < bkey) begin best = i; bkey = key; end
      end
    return best;
  endfunction

  task automatic model_check();
    logic [M-1:0] eg, ery, ers;
    logic         ehsel, erdy;
    logic [1:0]   etr;
    eg = '0; ehsel = 1'b0; etr = HTRANS_IDLE;
    if (m_act) begin
      eg    = M'(1) << m_own;
      ehsel = mstHSEL[m_own];
      etr   = mstHTRANS[m_own];
    end
    chk("m_grant", 64'(master_granted), 64'(eg));
    chk("m_hsel", 64'(slv_HSEL), 64'(ehsel));
    chk("m_htrans", 64'(slv_HTRANS), 64'(etr));
    if (m_act) begin
      chk("m_haddr", slv_HADDR, mstHADDR[m_own]);
      chk("m_ctrl", 64'({slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HMASTLOCK}),
          64'({mstHWRITE[m_own], mstHSIZE[m_own], mstHBURST[m_own], mstHPROT[m_own],
               mstHMASTLOCK[m_own]}));
    end
    ery = '1; ers = '0; erdy = 1'b1;
    if (m_dv) begin
      chk("m_hwdata", slv_HWDATA, mstHWDATA[m_down]);
      erdy = mstHREADY[m_down];
      ery  = ~(M'(1) << m_down) | (M'(slv_HREADYOUT) << m_down);
      ers  = M'(slv_HRESP) << m_down;
    end
    chk("m_hready", 64'(slv_HREADY), 64'(erdy));
    chk("m_hreadyout", 64'(mst_HREADYOUT), 64'(ery));
    chk("m_hresp", 64'(mst_HRESP), 64'(ers));
    chk("m_hrdata", mst_HRDATA, slv_HRDATA);
  endtask

  // One clock: compare at the falling edge, advance the model with the
  // inputs seen at the rising edge, return just after that edge.
  task automatic cycle();
    bit n_act, n_dv; logic [2:0] n_own, n_down; int n_last, w;
    @(negedge HCLK);
    model_check();
    n_act = m_act; n_own = m_own; n_down = m_down; n_dv = m_dv; n_last = m_last;
    w = pick();
    if (!HRESETn) begin
      n_act = 1'b0; n_own = '0; n_down = '0; n_dv = 1'b0; n_last = M-1;
    end else begin
      if (slv_HREADYOUT) begin
        n_down = m_own;
        n_dv   = m_act && mstHSEL[m_own] && (mstHTRANS[m_own] != HTRANS_IDLE);
      end
      if (!m_act) begin
        if (w >= 0) begin n_act = 1'b1; n_own = 3'(w); n_last = w; end
      end else if (slv_HREADYOUT && can_switch[m_own] && !mstHMASTLOCK[m_own]) begin
        if (w >= 0) begin n_own = 3'(w); n_last = w; end
        else n_act = 1'b0;
      end
    end
    @(posedge HCLK);
    m_act = n_act; m_own = n_own; m_down = n_down; m_dv = n_dv; m_last = n_last;
    #1;
  endtask

  task automatic clr();
    mstpriority = '0; mstHSEL = '0; mstHADDR = '0; mstHWDATA = '0; mstHWRITE = '0;
    mstHSIZE = '0; mstHBURST = '0; mstHPROT = '0; mstHTRANS = '0; mstHMASTLOCK = '0;
    mstHREADY = '1; can_switch = '0;
    slv_HREADYOUT = 1'b1; slv_HRESP = HRESP_OKAY; slv_HRDATA = '0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    cycle();
    HRESETn = 1'b1;
  endtask

  logic [M-1:0] rr_exp [4];

  initial begin
    HRESETn = 1'b0;
    clr();
    tbl[0] = '{5'b00100, {3'd0, 3'd0, 3'd3, 3'd0, 3'd0}, 5'b00100};
    tbl[1] = '{5'b00011, {3'd0, 3'd0, 3'd0, 3'd5, 3'd2}, 5'b00010};
    tbl[2] = '{5'b11111, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 5'b00001};
    tbl[3] = '{5'b10001, {3'd7, 3'd0, 3'd0, 3'd0, 3'd1}, 5'b10000};
    tbl[4] = '{5'b01110, {3'd0, 3'd6, 3'd6, 3'd6, 3'd0}, 5'b00010};
    tbl[5] = '{5'b00000, {3'd7, 3'd7, 3'd7, 3'd7, 3'd7}, 5'b00000};
    tbl[6] = '{5'b10100, {3'd7, 3'd0, 3'd7, 3'd0, 3'd0}, 5'b00100};
    tbl[7] = '{5'b01001, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, 5'b01000};
    tbl[8] = '{5'b11000, {3'd3, 3'd5, 3'd0, 3'd0, 3'd7}, 5'b01000};
`ifdef MSI_SLAVE_PORT_RR_EN
    rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b00001};
`else
    rr_exp = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif

    // Reset state
    do_reset();
    chk("rst_grant", 64'(master_granted), 64'(0));
    chk("rst_hsel", 64'(slv_HSEL), 64'(0));
    chk("rst_htrans", 64'(slv_HTRANS), 64'(HTRANS_IDLE));
    chk("rst_hreadyout", 64'(mst_HREADYOUT), 64'(5'b11111));
    chk("rst_hresp", 64'(mst_HRESP), 64'(0));

    // Arbitration table, each vector from a fresh reset
    for (int v = 0; v < 9; v++) begin
      clr(); do_reset();
      mstHSEL = tbl[v].req; mstpriority = tbl[v].prio;
      for (int i = 0; i < M; i++) mstHTRANS[i] = tbl[v].req[i] ? HTRANS_NONSEQ : HTRANS_IDLE;
      cycle();
      chk($sformatf("tbl%0d_grant", v), 64'(master_granted), 64'(tbl[v].want));
      chk($sformatf("tbl%0d_hsel", v), 64'(slv_HSEL), 64'(tbl[v].want != 0));
    end

    // Single write from master 2
    clr(); do_reset();
    mstHSEL[2] = 1'b1; mstpriority[2] = 3'd3; mstHTRANS[2] = HTRANS_NONSEQ;
    mstHADDR[2] = 64'h100; mstHWRITE[2] = 1'b1; mstHBURST[2] = HBURST_SINGLE;
    mstHWDATA[2] = 64'hA5; mstHSIZE[2] = 3'd2;
    #1 chk("w_nogrant_yet", 64'(master_granted), 64'(0));
    cycle();
    chk("w_grant", 64'(master_granted), 64'(5'b00100));
    chk("w_hsel", 64'(slv_HSEL), 64'(1));
    chk("w_haddr", slv_HADDR, 64'h100);
    chk("w_hwrite", 64'(slv_HWRITE), 64'(1));
    cycle();
    mstHSEL[2] = 1'b0; mstHTRANS[2] = HTRANS_IDLE; slv_HREADYOUT = 1'b0;
    #1 chk("w_hwdata", slv_HWDATA, 64'hA5);
    chk("w_hreadyout_wait", 64'(mst_HREADYOUT), 64'(5'b11011));
    cycle();
    slv_HREADYOUT = 1'b1;
    #1 chk("w_hreadyout_done", 64'(mst_HREADYOUT), 64'(5'b11111));
    cycle();

    // Priority 2 vs 5, switch on can_switch
    clr(); do_reset();
    mstHSEL[1:0] = 2'b11; mstpriority[0] = 3'd2; mstpriority[1] = 3'd5;
    mstHTRANS[0] = HTRANS_NONSEQ; mstHTRANS[1] = HTRANS_NONSEQ;
    cycle(); chk("p_grant1", 64'(master_granted), 64'(5'b00010));
    cycle(); chk("p_hold", 64'(master_granted), 64'(5'b00010));
    can_switch[1] = 1'b1; mstHSEL[1] = 1'b0; mstHTRANS[1] = HTRANS_IDLE;
    cycle(); chk("p_grant0", 64'(master_granted), 64'(5'b00001));

    // Locked INCR4 burst holds off a priority-7 requester
    clr(); do_reset();
    mstHSEL[3] = 1'b1; mstHMASTLOCK[3] = 1'b1; mstHTRANS[3] = HTRANS_NONSEQ;
    mstHBURST[3] = HBURST_INCR4; mstpriority[3] = 3'd1; can_switch[3] = 1'b1;
    cycle(); chk("l_grant3", 64'(master_granted), 64'(5'b01000));
    mstHSEL[4] = 1'b1; mstpriority[4] = 3'd7; mstHTRANS[4] = HTRANS_NONSEQ;
    mstHTRANS[3] = HTRANS_SEQ;
    for (int k = 0; k < 3; k++) begin
      cycle(); chk($sformatf("l_locked%0d", k), 64'(master_granted), 64'(5'b01000));
    end
    mstHMASTLOCK[3] = 1'b0;
    cycle(); chk("l_grant4", 64'(master_granted), 64'(5'b10000));

    // Read with three wait states; grant frozen meanwhile
    clr(); do_reset();
    mstHSEL[1] = 1'b1; mstpriority[1] = 3'd2; mstHTRANS[1] = HTRANS_NONSEQ;
    mstHADDR[1] = 64'h200;
    cycle(); cycle();
    mstHTRANS[1] = HTRANS_IDLE; can_switch[1] = 1'b1;
    mstHSEL[0] = 1'b1; mstpriority[0] = 3'd7; mstHTRANS[0] = HTRANS_NONSEQ;
    slv_HREADYOUT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("ws_rdy%0d", k), 64'(mst_HREADYOUT), 64'(5'b11101));
      chk($sformatf("ws_grant%0d", k), 64'(master_granted), 64'(5'b00010));
      cycle();
    end
    slv_HREADYOUT = 1'b1; slv_HRDATA = 64'hDEAD;
    #1 chk("ws_rdy_done", 64'(mst_HREADYOUT), 64'(5'b11111));
    chk("ws_hrdata", mst_HRDATA, 64'hDEAD);
    chk("ws_grant_held", 64'(master_granted), 64'(5'b00010));
    cycle(); chk("ws_grant0", 64'(master_granted), 64'(5'b00001));

    // Equal-priority tie break order
    clr(); do_reset();
    mstHSEL[2:0] = 3'b111; can_switch[2:0] = 3'b111;
    for (int i = 0; i < 3; i++) begin mstpriority[i] = 3'd4; mstHTRANS[i] = HTRANS_NONSEQ; end
    for (int k = 0; k < 4; k++) begin
      cycle(); chk($sformatf("tie%0d", k), 64'(master_granted), 64'(rr_exp[k]));
    end

    // Reset in the middle of a write data phase
    clr(); do_reset();
    mstHSEL[2] = 1'b1; mstpriority[2] = 3'd3; mstHTRANS[2] = HTRANS_NONSEQ;
    mstHWRITE[2] = 1'b1; mstHWDATA[2] = 64'h77;
    cycle(); cycle();
    HRESETn = 1'b0;
    cycle();
    HRESETn = 1'b1;
    #1 chk("r_hsel", 64'(slv_HSEL), 64'(0));
    chk("r_grant", 64'(master_granted), 64'(0));
    chk("r_hreadyout", 64'(mst_HREADYOUT), 64'(5'b11111));
    cycle();
    chk("r_regrant", 64'(master_granted), 64'(5'b00100));
    chk("r_rehsel", 64'(slv_HSEL), 64'(1));

    // Randomized traffic against the model
    clr(); do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < M; i++) begin
        mstpriority[i]  = 3'($urandom_range(0, 7));
        mstHADDR[i]     = {$urandom, $urandom};
        mstHWDATA[i]    = {$urandom, $urandom};
        mstHTRANS[i]    = 2'($urandom_range(0, 3));
        mstHSIZE[i]     = 3'($urandom_range(0, 7));
        mstHBURST[i]    = 3'($urandom_range(0, 7));
        mstHPROT[i]     = 4'($urandom_range(0, 15));
        mstHWRITE[i]    = 1'($urandom_range(0, 1));
        mstHMASTLOCK[i] = ($urandom_range(0, 7) == 0);
        mstHREADY[i]    = ($urandom_range(0, 5) != 0);
      end
      mstHSEL       = 5'($urandom_range(0, 31));
      can_switch    = 5'($urandom_range(0, 31));
      slv_HREADYOUT = ($urandom_range(0, 3) != 0);
      slv_HRESP     = ($urandom_range(0, 7) == 0);
      slv_HRDATA    = {$urandom, $urandom};
      HRESETn       = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
